// File: rtl/vita49_unpack.sv
// VITA-49 IF-data-with-stream-ID unpacker: validates and strips the 5-word
// prologue, forwards the payload with TLAST, and reports timestamps, status and error counts.
module vita49_unpack #(
    parameter int HDR_WORDS = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   AXIS_ACLK,
    input  logic                   AXIS_ARESETN,
    input  logic [31:0]            S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    input  logic                   S_AXIS_TLAST,
    output logic                   S_AXIS_TREADY,
    output logic [31:0]            M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    output logic                   M_AXIS_TLAST,
    input  logic                   M_AXIS_TREADY,
    input  logic [31:0]            ctrl,
    input  logic [31:0]            streamID,
    output logic [31:0]            status,
    output logic [31:0]            ts_sec,
    output logic [63:0]            ts_fsec,
    output logic                   ts_valid,
    output logic [15:0]            good_pkts,
    output logic [4*ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SID, S_TSI, S_TSF0, S_TSF1, S_PAYLOAD, S_DROP
    } state_t;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    state_t                 state_reg;
    logic [15:0]            pkt_size_reg;
    logic [3:0]             pkt_cnt_reg;
    logic [3:0]             prev_cnt_reg;
    logic                   seq_first_reg;
    logic                   pkt_err_reg;
    logic [15:0]            word_cnt_reg;
    logic [31:0]            tsi_reg;
    logic [31:0]            tsf0_reg;
    logic [31:0]            ts_sec_reg;
    logic [63:0]            ts_fsec_reg;
    logic                   ts_valid_reg;
    logic [15:0]            good_reg;
    logic [ERR_CNT_W-1:0]   err_reg [4];

    logic       enable, reset_cmd, passthrough, drop_on_sid;
    logic       accept, count_end, hdr_ok, seq_bad, sid_bad, good_inc;
    logic [3:0] err_inc;
    logic [3:0] next_cnt;
    state_t     boundary;
    logic       unused_ctrl;

    assign enable      = ctrl[0];
    assign reset_cmd   = ctrl[1];
    assign passthrough = ctrl[2];
    assign drop_on_sid = ctrl[3];
    assign unused_ctrl = &{1'b0, ctrl[31:4]};

    assign accept    = S_AXIS_TVALID & S_AXIS_TREADY;
    assign count_end = (word_cnt_reg == pkt_size_reg - 16'd1);
    assign hdr_ok    = (S_AXIS_TDATA[31:28] == 4'b0001) &&
                       (S_AXIS_TDATA[15:0] >= 16'(HDR_WORDS + 1));
    assign next_cnt  = prev_cnt_reg + 4'd1;
    assign seq_bad   = !seq_first_reg && (S_AXIS_TDATA[19:16] != next_cnt);
    assign sid_bad   = (S_AXIS_TDATA != streamID);
    assign boundary  = enable ? S_HDR : S_IDLE;

    // Payload is a zero-latency pass-through; every other state sinks words or stalls.
    always_comb begin
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TDATA  = 32'd0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        if (passthrough) begin
            S_AXIS_TREADY = M_AXIS_TREADY;
            M_AXIS_TDATA  = S_AXIS_TDATA;
            M_AXIS_TVALID = S_AXIS_TVALID;
            M_AXIS_TLAST  = S_AXIS_TLAST;
        end else begin
            case (state_reg)
                S_IDLE: S_AXIS_TREADY = 1'b0;
                S_PAYLOAD: begin
                    S_AXIS_TREADY = M_AXIS_TREADY;
                    M_AXIS_TDATA  = S_AXIS_TDATA;
                    M_AXIS_TVALID = S_AXIS_TVALID;
                    M_AXIS_TLAST  = S_AXIS_TLAST | count_end;
                end
                default: S_AXIS_TREADY = 1'b1;
            endcase
        end
    end

    // Error increments; bit order matches err_cnt = {hdr, sid, seq, len}.
    always_comb begin
        err_inc  = 4'd0;
        good_inc = 1'b0;
        if (!passthrough && !reset_cmd && accept) begin
            case (state_reg)
                S_HDR: begin
                    if (!hdr_ok) begin
                        err_inc[3] = 1'b1;
                    end else begin
                        err_inc[1] = seq_bad;
                        err_inc[0] = S_AXIS_TLAST;
                    end
                end
                S_SID: begin
                    err_inc[2] = sid_bad;
                    err_inc[0] = S_AXIS_TLAST;
                end
                S_TSI, S_TSF0, S_TSF1: err_inc[0] = S_AXIS_TLAST;
                S_PAYLOAD: begin
                    err_inc[0] = S_AXIS_TLAST ^ count_end;
                    good_inc   = S_AXIS_TLAST & count_end & !pkt_err_reg;
                end
                default: err_inc = 4'd0;
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_reg     <= S_IDLE;
            pkt_size_reg  <= 16'd0;
            pkt_cnt_reg   <= 4'd0;
            prev_cnt_reg  <= 4'd0;
            seq_first_reg <= 1'b1;
            pkt_err_reg   <= 1'b0;
            word_cnt_reg  <= 16'd0;
            tsi_reg       <= 32'd0;
            tsf0_reg      <= 32'd0;
            ts_sec_reg    <= 32'd0;
            ts_fsec_reg   <= 64'd0;
            ts_valid_reg  <= 1'b0;
        end else begin
            ts_valid_reg <= 1'b0;
            if (reset_cmd) begin
                pkt_size_reg  <= 16'd0;
                pkt_cnt_reg   <= 4'd0;
                prev_cnt_reg  <= 4'd0;
                seq_first_reg <= 1'b1;
                pkt_err_reg   <= 1'b0;
                // Mid-packet: flush the residue unless its TLAST is being taken right now.
                if (state_reg == S_IDLE || state_reg == S_HDR)
                    state_reg <= S_IDLE;
                else if (accept && S_AXIS_TLAST)
                    state_reg <= S_IDLE;
                else
                    state_reg <= S_DROP;
            end else if (!passthrough) begin
                case (state_reg)
                    S_IDLE: if (enable) state_reg <= S_HDR;
                    S_HDR: begin
                        if (accept) begin
                            pkt_err_reg <= 1'b0;
                            if (!hdr_ok) begin
                                state_reg <= S_AXIS_TLAST ? boundary : S_DROP;
                            end else begin
                                pkt_size_reg  <= S_AXIS_TDATA[15:0];
                                pkt_cnt_reg   <= S_AXIS_TDATA[19:16];
                                prev_cnt_reg  <= S_AXIS_TDATA[19:16];
                                seq_first_reg <= 1'b0;
                                pkt_err_reg   <= seq_bad;
                                state_reg     <= S_AXIS_TLAST ? boundary : S_SID;
                            end
                        end else if (!enable) begin
                            state_reg <= S_IDLE;
                        end
                    end
                    S_SID: if (accept) begin
                        if (sid_bad) pkt_err_reg <= 1'b1;
                        if (S_AXIS_TLAST)
                            state_reg <= boundary;
                        else if (sid_bad && drop_on_sid)
                            state_reg <= S_DROP;
                        else
                            state_reg <= S_TSI;
                    end
                    S_TSI: if (accept) begin
                        tsi_reg   <= S_AXIS_TDATA;
                        state_reg <= S_AXIS_TLAST ? boundary : S_TSF0;
                    end
                    S_TSF0: if (accept) begin
                        tsf0_reg  <= S_AXIS_TDATA;
                        state_reg <= S_AXIS_TLAST ? boundary : S_TSF1;
                    end
                    S_TSF1: if (accept) begin
                        ts_sec_reg   <= tsi_reg;
                        ts_fsec_reg  <= {tsf0_reg, S_AXIS_TDATA};
                        ts_valid_reg <= 1'b1;
                        word_cnt_reg <= 16'(HDR_WORDS);
                        state_reg    <= S_AXIS_TLAST ? boundary : S_PAYLOAD;
                    end
                    S_PAYLOAD: if (accept) begin
                        if (S_AXIS_TLAST)
                            state_reg <= boundary;
                        else if (count_end)
                            state_reg <= S_DROP;
                        else
                            word_cnt_reg <= word_cnt_reg + 16'd1;
                    end
                    S_DROP: if (accept && S_AXIS_TLAST) state_reg <= boundary;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN)
            good_reg <= 16'd0;
        else if (reset_cmd)
            good_reg <= 16'd0;
        else if (good_inc)
            good_reg <= good_reg + 16'd1;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_err
            always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
                if (!AXIS_ARESETN)
                    err_reg[gi] <= '0;
                else if (reset_cmd)
                    err_reg[gi] <= '0;
                else if (err_inc[gi] && err_reg[gi] != ERR_MAX)
                    err_reg[gi] <= err_reg[gi] + 1'b1;
            end
            assign err_cnt[gi*ERR_CNT_W +: ERR_CNT_W] = err_reg[gi];
        end
    endgenerate

    assign status    = {pkt_size_reg, 8'd0, pkt_cnt_reg, 2'd0,
                        (state_reg == S_DROP), (state_reg != S_IDLE)};
    assign ts_sec    = ts_sec_reg;
    assign ts_fsec   = ts_fsec_reg;
    assign ts_valid  = ts_valid_reg;
    assign good_pkts = good_reg;

endmodule
